// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall detection, post-jump flush
// sequencing, external hold arbitration and a saturating lost-cycle counter.
module pipe_hazard_ctrl #(
    parameter int unsigned STALL_CYCLES = 1,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_flag_i,
    input  logic [31:0]       jump_addr_i,
    input  logic              hold_ex_i,
    input  logic              hold_rib_i,
    input  logic              hold_clint_i,
    input  logic [4:0]        id_rs1_i,
    input  logic [4:0]        id_rs2_i,
    input  logic              id_rs1_re_i,
    input  logic              id_rs2_re_i,
    input  logic              ex_load_i,
    input  logic [4:0]        ex_rd_i,
    output logic [2:0]        hold_flag_o,
    output logic              stall_flag_o,
    output logic              jump_flag_o,
    output logic [31:0]       jump_addr_o,
    output logic [CNT_W-1:0]  lost_cnt_o
);

    localparam int unsigned CYC_W  = 4;
    localparam int unsigned ADDR_W = 32;

    localparam logic [2:0] HOLD_NONE = 3'b000;
    localparam logic [2:0] HOLD_PC   = 3'b001;
    localparam logic [2:0] HOLD_ID   = 3'b011;

    // Number of cycles spent in STALL/FLUSH after the request cycle itself
    localparam logic [CYC_W-1:0] STALL_LOAD = CYC_W'(STALL_CYCLES - 1);
    localparam logic [CYC_W-1:0] FLUSH_LOAD = CYC_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CYC_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  lost_q, lost_d;
    logic              lu;
    logic              flush_now;

    // Load-use hazard between the load in EX and the operands read in ID
    always_comb begin
        lu = ex_load_i && (ex_rd_i != 5'd0) &&
             ((id_rs1_re_i && (id_rs1_i == ex_rd_i)) ||
              (id_rs2_re_i && (id_rs2_i == ex_rd_i)));
    end

    // State, cycle counter and lost-cycle counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            lost_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lost_q  <= lost_d;
        end
    end

    // Next-state: jump restarts the flush; cnt holds remaining state cycles
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (jump_flag_i) begin
                    if (FLUSH_LOAD != '0) begin
                        state_d = ST_FLUSH;
                        cnt_d   = FLUSH_LOAD;
                    end
                end else if (lu) begin
                    if (STALL_LOAD != '0) begin
                        state_d = ST_STALL;
                        cnt_d   = STALL_LOAD;
                    end
                end
            end
            ST_STALL, ST_FLUSH: begin
                if (jump_flag_i) begin
                    if (FLUSH_LOAD != '0) begin
                        state_d = ST_FLUSH;
                        cnt_d   = FLUSH_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end else if (cnt_q <= CYC_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CYC_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode: covers the request cycle, all forced low during reset
    always_comb begin
        flush_now    = jump_flag_i || (state_q == ST_FLUSH);
        stall_flag_o = 1'b0;
        hold_flag_o  = HOLD_NONE;
        jump_flag_o  = 1'b0;
        jump_addr_o  = '0;
        if (!rst) begin
            stall_flag_o = !flush_now &&
                           ((lu && (state_q == ST_IDLE)) || (state_q == ST_STALL));
            if (flush_now || hold_ex_i || hold_clint_i) begin
                hold_flag_o = HOLD_ID;
            end else if (hold_rib_i) begin
                hold_flag_o = HOLD_PC;
            end
            jump_flag_o = jump_flag_i;
            jump_addr_o = ADDR_W'(jump_addr_i);
        end
    end

    // Saturating count of cycles lost to stalls or holds
    always_comb begin
        lost_d = lost_q;
        if ((stall_flag_o || (hold_flag_o != HOLD_NONE)) && (lost_q != '1)) begin
            lost_d = lost_q + CNT_W'(1);
        end
    end

    assign lost_cnt_o = lost_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: two instances sharing stimulus.
// dut_a: STALL=1, FLUSH=3, CNT_W=32.  dut_b: STALL=3, FLUSH=2, CNT_W=4.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        hold_ex_i, hold_rib_i, hold_clint_i;
    logic [4:0]  id_rs1_i, id_rs2_i, ex_rd_i;
    logic        id_rs1_re_i, id_rs2_re_i, ex_load_i;

    logic [2:0]  hold_a, hold_b;
    logic        stall_a, stall_b, jf_a, jf_b;
    logic [31:0] ja_a, ja_b;
    logic [31:0] lost_a;
    logic [3:0]  lost_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.STALL_CYCLES(1), .FLUSH_CYCLES(3), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
        .hold_ex_i(hold_ex_i), .hold_rib_i(hold_rib_i), .hold_clint_i(hold_clint_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rs1_re_i(id_rs1_re_i),
        .id_rs2_re_i(id_rs2_re_i), .ex_load_i(ex_load_i), .ex_rd_i(ex_rd_i),
        .hold_flag_o(hold_a), .stall_flag_o(stall_a), .jump_flag_o(jf_a),
        .jump_addr_o(ja_a), .lost_cnt_o(lost_a)
    );

    pipe_hazard_ctrl #(.STALL_CYCLES(3), .FLUSH_CYCLES(2), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
        .hold_ex_i(hold_ex_i), .hold_rib_i(hold_rib_i), .hold_clint_i(hold_clint_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rs1_re_i(id_rs1_re_i),
        .id_rs2_re_i(id_rs2_re_i), .ex_load_i(ex_load_i), .ex_rd_i(ex_rd_i),
        .hold_flag_o(hold_b), .stall_flag_o(stall_b), .jump_flag_o(jf_b),
        .jump_addr_o(ja_b), .lost_cnt_o(lost_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        jump_flag_i  = 1'b0;
        jump_addr_i  = 32'h0;
        hold_ex_i    = 1'b0;
        hold_rib_i   = 1'b0;
        hold_clint_i = 1'b0;
        id_rs1_i     = 5'd0;
        id_rs2_i     = 5'd0;
        id_rs1_re_i  = 1'b0;
        id_rs2_re_i  = 1'b0;
        ex_load_i    = 1'b0;
        ex_rd_i      = 5'd0;
    endtask

    // Load in EX writing x5, ID reads x5 via rs1
    task automatic haz();
        ex_load_i   = 1'b1;
        ex_rd_i     = 5'd5;
        id_rs1_i    = 5'd5;
        id_rs1_re_i = 1'b1;
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs
    task automatic settle();
        #1;
    endtask

    initial begin
        clr();
        rst = 1'b1;
        #2;
        check("rst_hold_a",  32'(hold_a),  32'd0);
        check("rst_stall_a", 32'(stall_a), 32'd0);
        check("rst_lost_a",  lost_a,       32'd0);
        cyc();
        rst = 1'b0;

        // T1: load-use hazard, both stall in the request cycle
        cyc(); haz(); settle();
        check("lu_stall_a", 32'(stall_a), 32'd1);
        check("lu_hold_a",  32'(hold_a),  32'd0);
        check("lu_stall_b", 32'(stall_b), 32'd1);
        // T2: A done after one cycle, B still stalling
        cyc(); clr(); settle();
        check("lu_end_a",  32'(stall_a), 32'd0);
        check("lu_lost_a", lost_a,       32'd1);
        check("lu2_b",     32'(stall_b), 32'd1);
        cyc(); settle();
        check("lu3_b", 32'(stall_b), 32'd1);
        cyc(); settle();
        check("lu_end_b",  32'(stall_b), 32'd0);
        check("lu_lost_b", 32'(lost_b),  32'd3);

        // T5: destination x0 never stalls
        cyc(); haz(); ex_rd_i = 5'd0; id_rs1_i = 5'd0; settle();
        check("x0_stall_a", 32'(stall_a), 32'd0);
        // T6: rs1 not read, rs2 does not match
        cyc(); clr(); haz(); id_rs1_re_i = 1'b0; id_rs2_i = 5'd7; id_rs2_re_i = 1'b1; settle();
        check("nore_stall_a", 32'(stall_a), 32'd0);
        check("nore_stall_b", 32'(stall_b), 32'd0);
        // T7: rs2 match stalls
        cyc(); id_rs2_i = 5'd5; settle();
        check("rs2_stall_a", 32'(stall_a), 32'd1);
        cyc(); clr(); cyc(); cyc(); settle();
        check("rs2_lost_b", 32'(lost_b), 32'd6);

        // T11: jump pulse, flush for FLUSH_CYCLES cycles
        cyc(); jump_flag_i = 1'b1; jump_addr_i = 32'h100; settle();
        check("jmp_flag_a", 32'(jf_a),   32'd1);
        check("jmp_addr_a", ja_a,        32'h100);
        check("jmp_hold1",  32'(hold_a), 32'd3);
        cyc(); clr(); settle();
        check("jmp_flag_off", 32'(jf_a),   32'd0);
        check("jmp_hold2",    32'(hold_a), 32'd3);
        check("jmp_hold2_b",  32'(hold_b), 32'd3);
        cyc(); settle();
        check("jmp_hold3",   32'(hold_a), 32'd3);
        check("jmp_end_b",   32'(hold_b), 32'd0);
        cyc(); settle();
        check("jmp_end_a",  32'(hold_a), 32'd0);
        check("jmp_lost_a", lost_a,      32'd5);

        // T15: hazard and jump together, flush wins
        cyc(); haz(); jump_flag_i = 1'b1; settle();
        check("lujmp_stall", 32'(stall_a), 32'd0);
        check("lujmp_hold",  32'(hold_a),  32'd3);
        cyc(); clr(); cyc(); cyc(); settle();
        check("lujmp_end", 32'(hold_a), 32'd0);

        // T19: 3-cycle stall in B interrupted by a jump in its 2nd cycle
        cyc(); haz(); settle();
        check("s3_stall1", 32'(stall_b), 32'd1);
        cyc(); clr(); jump_flag_i = 1'b1; settle();
        check("s3_jmp_stall", 32'(stall_b), 32'd0);
        check("s3_jmp_hold",  32'(hold_b),  32'd3);
        cyc(); clr(); settle();
        check("s3_fl2_hold",  32'(hold_b),  32'd3);
        check("s3_fl2_stall", 32'(stall_b), 32'd0);
        cyc(); settle();
        check("s3_idle_b", 32'(hold_b), 32'd0);
        cyc(); settle();
        check("s3_lost_a", lost_a, 32'd12);

        // T24: external holds
        cyc(); hold_rib_i = 1'b1; settle();
        check("rib_hold", 32'(hold_a), 32'd1);
        cyc(); hold_ex_i = 1'b1; settle();
        check("rib_ex_hold", 32'(hold_a), 32'd3);
        cyc(); hold_rib_i = 1'b0; hold_ex_i = 1'b0; hold_clint_i = 1'b1; settle();
        check("clint_hold", 32'(hold_a), 32'd3);
        cyc(); hold_clint_i = 1'b0; hold_rib_i = 1'b1; settle();
        cyc(); clr(); settle();
        check("sat_lost_b", 32'(lost_b), 32'd15);
        check("nosat_lost_a", lost_a,    32'd16);

        // Asynchronous reset in the middle of a flush
        cyc(); jump_flag_i = 1'b1; jump_addr_i = 32'h200; settle();
        cyc(); jump_flag_i = 1'b1; jump_addr_i = 32'h300; hold_ex_i = 1'b1; haz(); settle();
        check("pre_rst_hold", 32'(hold_a), 32'd3);
        #1 rst = 1'b1;
        #1;
        check("arst_hold",  32'(hold_a),  32'd0);
        check("arst_stall", 32'(stall_a), 32'd0);
        check("arst_jf",    32'(jf_a),    32'd0);
        check("arst_ja",    ja_a,         32'h0);
        check("arst_lost",  lost_a,       32'd0);
        rst = 1'b0;
        clr();
        cyc(); settle();
        check("post_rst_hold", 32'(hold_a), 32'd0);
        check("post_rst_lost", lost_a,      32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
